// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream logic.
// Provides the read-buffer state encoding, which doubles as the occupancy count.
package fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   // Encoding equals the number of buffered words (0..2).
   typedef enum logic [1:0] {
      RD_EMPTY = 2'd0,
      RD_ONE   = 2'd1,
      RD_FULL2 = 2'd2
   } rd_state_t;

endpackage

// File: rtl/fifo_stream_reader.sv
// FIFO read-side consumer: pops words while not empty, buffers them in a
// head+skid pair and presents them as a valid/ready stream framed into packets.
// Ports: clk, areset (async, active-high), flush (sync discard/restart),
//   fifo_empty/fifo_rdata/fifo_read (FIFO side, read is combinational),
//   pkt_len (beats per packet, 0 = 2**len_width),
//   m_valid/m_ready/m_data/m_last (output stream), occ (buffered words).
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int data_width = DEFAULT_DATA_WIDTH,
   parameter int len_width  = 8
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  flush,
   input  logic                  fifo_empty,
   input  logic [data_width-1:0] fifo_rdata,
   output logic                  fifo_read,
   input  logic [len_width-1:0]  pkt_len,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [data_width-1:0] m_data,
   output logic                  m_last,
   output logic [1:0]            occ
);

   localparam logic [len_width-1:0] LEN_ONE = len_width'(1);

   rd_state_t             r_state;
   logic [data_width-1:0] r_head;
   logic [data_width-1:0] r_skid;
   logic [len_width-1:0]  r_beat_cnt;
   logic [len_width-1:0]  r_len_q;

   rd_state_t             w_state_nxt;
   logic [data_width-1:0] w_head_nxt;
   logic [data_width-1:0] w_skid_nxt;
   logic [len_width-1:0]  w_beat_nxt;
   logic [len_width-1:0]  w_len_eff;
   logic [len_width-1:0]  w_len_m1;
   logic                  w_take;
   logic                  w_pop;

   // Pop decision depends only on registered state and FIFO/flush inputs,
   // never on m_ready, so there is no combinational ready->read path.
   assign w_pop     = ~areset & ~fifo_empty & ~flush & (r_state != RD_FULL2);
   assign fifo_read = w_pop;

   assign m_valid = (r_state != RD_EMPTY);
   assign m_data  = r_head;
   assign occ     = r_state;
   assign w_take  = m_valid & m_ready;

   // The first beat of a packet uses the live pkt_len; later beats use the
   // value latched at packet start. Length 0 wraps to all-ones (2**len_width).
   assign w_len_eff = (r_beat_cnt == '0) ? pkt_len : r_len_q;
   assign w_len_m1  = w_len_eff - LEN_ONE;
   assign m_last    = m_valid & (r_beat_cnt == w_len_m1);

   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_skid_nxt  = r_skid;
      case (r_state)
         RD_EMPTY: begin
            if (w_pop) begin
               w_state_nxt = RD_ONE;
               w_head_nxt  = fifo_rdata;
            end
         end
         RD_ONE: begin
            if (w_pop & w_take) begin
               w_head_nxt = fifo_rdata;
            end else if (w_pop) begin
               w_state_nxt = RD_FULL2;
               w_skid_nxt  = fifo_rdata;
            end else if (w_take) begin
               w_state_nxt = RD_EMPTY;
            end
         end
         RD_FULL2: begin
            if (w_take) begin
               w_state_nxt = RD_ONE;
               w_head_nxt  = r_skid;
            end
         end
         default: w_state_nxt = RD_EMPTY;
      endcase
      if (flush) begin
         w_state_nxt = RD_EMPTY;
      end
   end

   always_comb begin
      w_beat_nxt = r_beat_cnt;
      if (flush) begin
         w_beat_nxt = '0;
      end else if (w_take & m_last) begin
         w_beat_nxt = '0;
      end else if (w_take) begin
         w_beat_nxt = r_beat_cnt + LEN_ONE;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state    <= RD_EMPTY;
         r_head     <= '0;
         r_skid     <= '0;
         r_beat_cnt <= '0;
         r_len_q    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_head     <= w_head_nxt;
         r_skid     <= w_skid_nxt;
         r_beat_cnt <= w_beat_nxt;
         if (r_beat_cnt == '0) begin
            r_len_q <= pkt_len;
         end
      end
   end

endmodule
